// File: rtl/wallace_final_adder_if.sv
// Handshake/bus bundle for wallace_final_adder.
//   in_valid/in_ready : operand-pair handshake from the reduction tree
//   row_s/row_c       : final sum row and weight-aligned carry row
//   out_valid/out_ready : result handshake to the consumer
//   product/cout      : (row_s + row_c) mod 2^WIDTH and carry out of bit WIDTH-1
// master = producer/consumer side, slave = the adder.
interface wallace_final_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] row_s;
  logic [WIDTH-1:0] row_c;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] product;
  logic             cout;

  modport master (
    output in_valid, row_s, row_c, out_ready,
    input  in_ready, out_valid, product, cout
  );

  modport slave (
    input  in_valid, row_s, row_c, out_ready,
    output in_ready, out_valid, product, cout
  );
endinterface

// File: rtl/wallace_final_adder.sv
// Final carry-propagate adder for a Wallace-tree multiplier. Adds the sum
// row and the carry row CHUNK bits per cycle (ripple across cycles), then
// holds the result until the consumer takes it.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : wallace_final_adder_if.slave (operand and result handshakes)
// WIDTH must be an integer multiple of CHUNK.
module wallace_final_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  wallace_final_adder_if.slave bus
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] s_q, c_q, product_q;
  logic [KW-1:0]    k_q;
  logic             carry_q, cout_q;
  logic [CHUNK:0]   csum;
  logic             last;

  // One chunk of the ripple: slice k of both captured rows plus running carry.
  always_comb begin
    csum = {1'b0, s_q[k_q*CHUNK +: CHUNK]}
         + {1'b0, c_q[k_q*CHUNK +: CHUNK]}
         + {{CHUNK{1'b0}}, carry_q};
  end

  assign last = (k_q == KLAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)  state_d = ADD;
      ADD:     if (last)          state_d = HOLD;
      HOLD:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q       <= '0;
      c_q       <= '0;
      product_q <= '0;
      k_q       <= '0;
      carry_q   <= 1'b0;
      cout_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            s_q     <= bus.row_s;
            c_q     <= bus.row_c;
            k_q     <= '0;
            carry_q <= 1'b0;
          end
        end
        ADD: begin
          product_q[k_q*CHUNK +: CHUNK] <= csum[CHUNK-1:0];
          carry_q <= csum[CHUNK];
          k_q     <= k_q + 1'b1;
          if (last) cout_q <= csum[CHUNK];
        end
        default: ;
      endcase
    end
  end

  // Handshakes decode registered state only.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.product   = product_q;
  assign bus.cout      = cout_q;

endmodule

// File: tb/tb_wallace_final_adder.sv
// Directed self-checking bench for wallace_final_adder (WIDTH=16, CHUNK=4).
module tb_wallace_final_adder;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CHUNK = 4;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  wallace_final_adder_if #(.WIDTH(WIDTH)) bus ();

  wallace_final_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sample point: 1 time unit after the rising edge.
  task automatic wait_clk();
    @(posedge clk);
    #1;
  endtask

  // Full transaction from IDLE: accept, scramble inputs, latency, result, release.
  task automatic run_op(input string tag, input logic [15:0] s, input logic [15:0] c,
                        input logic [15:0] exp_p, input logic exp_co);
    int n;
    bus.row_s    = s;
    bus.row_c    = c;
    bus.in_valid = 1'b1;
    wait_clk();
    bus.in_valid = 1'b0;
    bus.row_s    = 16'hDEAD;
    bus.row_c    = 16'hBEEF;
    check({tag, "_accept_in_ready"}, 32'(bus.in_ready), 32'd0);
    n = 0;
    while (n < 20) begin
      wait_clk();
      n++;
      if (bus.out_valid) break;
    end
    check({tag, "_latency"}, n, 4);
    check({tag, "_product"}, 32'(bus.product), 32'(exp_p));
    check({tag, "_cout"},    32'(bus.cout), 32'(exp_co));
    bus.out_ready = 1'b1;
    wait_clk();
    bus.out_ready = 1'b0;
    check({tag, "_idle_in_ready"},  32'(bus.in_ready), 32'd1);
    check({tag, "_idle_out_valid"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    logic [15:0] s, c;
    logic [16:0] exp_q[$];
    logic [16:0] e;
    int sent, got, hi;
    logic acc, prev_ov;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.row_s     = '0;
    bus.row_c     = '0;
    bus.out_ready = 1'b0;

    // Reset values, asserted before any clock edge.
    #3;
    check("rst_in_ready",  32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_product",   32'(bus.product), 32'd0);
    check("rst_cout",      32'(bus.cout), 32'd0);
    wait_clk();
    wait_clk();
    rst_n = 1'b1;

    // First edge after release accepts.
    run_op("t13x11", 16'h0085, 16'h000A, 16'h008F, 1'b0);
    run_op("chain12", 16'h0FFF, 16'h0001, 16'h1000, 1'b0);
    run_op("chain16", 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
    run_op("maxmax",  16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1);
    run_op("msb",     16'h8000, 16'h8000, 16'h0000, 1'b1);

    // Backpressure in HOLD with stray in_valid and different data.
    bus.row_s    = 16'h1234;
    bus.row_c    = 16'h4321;
    bus.in_valid = 1'b1;
    wait_clk();
    bus.in_valid = 1'b0;
    repeat (4) wait_clk();
    check("bp_enter_hold", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.row_s    = 16'hAAAA;
      bus.row_c    = 16'h1111;
      wait_clk();
      check("bp_product",   32'(bus.product), 32'h5555);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_in_ready",  32'(bus.in_ready), 32'd0);
    end
    check("bp_cout", 32'(bus.cout), 32'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_clk();
    bus.out_ready = 1'b0;
    check("bp_release_in_ready",  32'(bus.in_ready), 32'd1);
    check("bp_release_out_valid", 32'(bus.out_valid), 32'd0);

    // Reset in the middle of ADD.
    bus.row_s    = 16'h00FF;
    bus.row_c    = 16'h0001;
    bus.in_valid = 1'b1;
    wait_clk();
    bus.in_valid = 1'b0;
    wait_clk();
    wait_clk();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready",  32'(bus.in_ready), 32'd1);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_product",   32'(bus.product), 32'd0);
    check("midrst_cout",      32'(bus.cout), 32'd0);
    wait_clk();
    wait_clk();
    rst_n = 1'b1;
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      wait_clk();
      if (bus.out_valid) hi++;
    end
    check("midrst_no_out_valid", hi, 0);
    run_op("post_rst", 16'h00FF, 16'h0001, 16'h0100, 1'b0);

    // Back-to-back with in_valid and out_ready held high.
    s = 16'($urandom);
    c = 16'($urandom);
    bus.row_s     = s;
    bus.row_c     = c;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    sent = 0;
    got = 0;
    prev_ov = 1'b0;
    for (int cyc = 0; cyc < 100 && got < 3; cyc++) begin
      acc = bus.in_ready & bus.in_valid;
      wait_clk();
      if (acc) begin
        exp_q.push_back({1'b0, s} + {1'b0, c});
        sent++;
        if (sent == 3) begin
          bus.in_valid = 1'b0;
        end else begin
          s = 16'($urandom);
          c = 16'($urandom);
          bus.row_s = s;
          bus.row_c = c;
        end
      end
      if (bus.out_valid) begin
        check("b2b_single_pulse", 32'(prev_ov), 32'd0);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("b2b_product", 32'(bus.product), 32'(e[15:0]));
          check("b2b_cout",    32'(bus.cout), 32'(e[16]));
        end else begin
          check("b2b_unexpected_result", 32'd1, 32'(exp_q.size()));
        end
        got++;
      end
      prev_ov = bus.out_valid;
    end
    bus.out_ready = 1'b0;
    check("b2b_count", got, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
